// File: rtl/pscan_pkg.sv
// Shared types and helpers for the priority scan serializer.
// Build option: PSCAN_MSB_FIRST_EN reverses priority (MSB first).
package pscan_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      SCAN = 1'b1
   } pscan_state_e;

   // Widest request vector the helper covers; 8-bit index spans it.
   localparam int PSCAN_MAX_W = 256;
   localparam int PSCAN_IDX_W = 8;

   function automatic logic [PSCAN_MAX_W-1:0] onehot_clear(
      input logic [PSCAN_MAX_W-1:0] vec,
      input logic [PSCAN_IDX_W-1:0] idx
   );
      logic [PSCAN_MAX_W-1:0] m;
      m      = '0;
      m[idx] = 1'b1;
      return vec & ~m;
   endfunction

endpackage

// File: rtl/priority_scan_serializer_pick.sv
// Combinational pick of the highest-priority set bit of a vector.
// Build option: PSCAN_MSB_FIRST_EN picks the highest set index.
module priority_pick #(
   parameter  int INP_BIT = 8,
   localparam int OUT_BIT = $clog2(INP_BIT)
) (
   input  logic [INP_BIT-1:0] vec,
   output logic [OUT_BIT-1:0] idx,
   output logic               found,
   output logic               single
);

   always_comb begin
      idx = '0;
`ifdef PSCAN_MSB_FIRST_EN
      for (int i = 0; i < INP_BIT; i++) begin
         if (vec[i]) idx = OUT_BIT'(i);
      end
`else
      // Descending walk: the last hit is the lowest set index.
      for (int i = INP_BIT - 1; i >= 0; i--) begin
         if (vec[i]) idx = OUT_BIT'(i);
      end
`endif
   end

   assign found  = |vec;
   assign single = found && ((vec & (vec - INP_BIT'(1))) == '0);

endmodule

// File: rtl/priority_scan_serializer.sv
// Accepts a request vector and emits each set index, one per handshake.
// Build option: PSCAN_MSB_FIRST_EN emits indices from MSB to LSB.
module priority_scan_serializer
   import pscan_pkg::*;
#(
   parameter  int INP_BIT = 8,
   localparam int OUT_BIT = $clog2(INP_BIT)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [INP_BIT-1:0] in_vec,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [OUT_BIT-1:0] out_idx,
   output logic               out_last,
   output logic               zero_err,
   output logic               busy
);

   pscan_state_e       r_state;
   logic [INP_BIT-1:0] r_pend;
   logic               r_zero_err;

   logic [OUT_BIT-1:0] w_idx;
   logic               w_found;
   logic               w_single;
   logic               w_scan;
   logic               w_acc;
   logic               w_ohs;
   logic               w_vec_nz;

   priority_pick #(
      .INP_BIT (INP_BIT)
   ) u_pick (
      .vec    (r_pend),
      .idx    (w_idx),
      .found  (w_found),
      .single (w_single)
   );

   assign w_scan   = (r_state == SCAN);
   assign w_vec_nz = |in_vec;

   assign out_valid = w_scan;
   assign busy      = w_scan;
   assign out_last  = w_scan && w_single;
   assign out_idx   = w_found ? w_idx : '0;
   assign zero_err  = r_zero_err;

   // Final handshake frees the slot so the next vector loads with no bubble.
   assign in_ready = !w_scan || (w_single && out_ready);
   assign w_acc    = in_valid && in_ready;
   assign w_ohs    = w_scan && out_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= IDLE;
         r_pend     <= '0;
         r_zero_err <= 1'b0;
      end else begin
         r_zero_err <= w_acc && !w_vec_nz;
         unique case (r_state)
            IDLE: begin
               if (w_acc && w_vec_nz) begin
                  r_pend  <= in_vec;
                  r_state <= SCAN;
               end
            end
            SCAN: begin
               if (w_ohs) begin
                  if (w_acc) begin
                     r_pend  <= in_vec;
                     r_state <= w_vec_nz ? SCAN : IDLE;
                  end else begin
                     r_pend <= INP_BIT'(onehot_clear(
                        PSCAN_MAX_W'(r_pend), PSCAN_IDX_W'(w_idx)));
                     if (w_single) r_state <= IDLE;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_priority_scan_serializer.sv
// Bench for priority_scan_serializer: directed cases plus random traffic
// checked every cycle against a queue-based model of pending indices.
module tb_priority_scan_serializer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] in_vec = '0;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [2:0] out_idx;
   logic       out_last;
   logic       zero_err;
   logic       busy;

   logic        v32 = 1'b0;
   logic        rdy32;
   logic [31:0] vec32 = '0;
   logic        ov32;
   logic        or32 = 1'b0;
   logic [4:0]  idx32;
   logic        last32;
   logic        ze32;
   logic        busy32;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   priority_scan_serializer #(.INP_BIT(8)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_vec(in_vec), .out_valid(out_valid), .out_ready(out_ready),
      .out_idx(out_idx), .out_last(out_last), .zero_err(zero_err),
      .busy(busy)
   );

   priority_scan_serializer #(.INP_BIT(32)) dut32 (
      .clk(clk), .rst(rst), .in_valid(v32), .in_ready(rdy32),
      .in_vec(vec32), .out_valid(ov32), .out_ready(or32),
      .out_idx(idx32), .out_last(last32), .zero_err(ze32),
      .busy(busy32)
   );

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: remaining indices of the current vector, in emission order.
   int q[$];
   bit m_zero = 1'b0;

   function automatic void load_q(input logic [7:0] v);
      q.delete();
`ifdef PSCAN_MSB_FIRST_EN
      for (int i = 7; i >= 0; i--) if (v[i]) q.push_back(i);
`else
      for (int i = 0; i < 8; i++) if (v[i]) q.push_back(i);
`endif
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         q.delete();
         m_zero = 1'b0;
      end else begin
         bit rdy, acc;
         rdy = (q.size() == 0) || (q.size() == 1 && out_ready);
         acc = in_valid && rdy;
         m_zero = acc && (in_vec == 8'h00);
         if (q.size() > 0 && out_ready) void'(q.pop_front());
         if (acc && in_vec != 8'h00) load_q(in_vec);
      end
   end

   always @(negedge clk) begin
      int n;
      n = q.size();
      chk("m_valid", int'(out_valid), int'(n > 0));
      chk("m_busy", int'(busy), int'(n > 0));
      chk("m_idx", int'(out_idx), n > 0 ? q[0] : 0);
      chk("m_last", int'(out_last), int'(n == 1));
      chk("m_ready", int'(in_ready), int'(n == 0 || (n == 1 && out_ready)));
      chk("m_zero", int'(zero_err), int'(m_zero));
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   int exp1[4];
   int e81[2];
   int e32[2];

   initial begin
`ifdef PSCAN_MSB_FIRST_EN
      exp1 = '{7, 5, 2, 1};
      e81  = '{7, 0};
      e32  = '{31, 0};
`else
      exp1 = '{1, 2, 5, 7};
      e81  = '{0, 7};
      e32  = '{0, 31};
`endif
      @(negedge clk);
      chk("rst_valid", int'(out_valid), 0);
      chk("rst_ready", int'(in_ready), 1);
      chk("rst_idx", int'(out_idx), 0);
      tick();
      tick();
      rst = 1'b0;

      // Vector 1010_0110 at full throughput.
      in_valid = 1'b1; in_vec = 8'b1010_0110; out_ready = 1'b1;
      tick();
      in_valid = 1'b0; in_vec = 8'hFF;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("t1_valid", int'(out_valid), 1);
         chk("t1_idx", int'(out_idx), exp1[k]);
         chk("t1_last", int'(out_last), int'(k == 3));
         tick();
      end
      @(negedge clk);
      chk("t1_idle", int'(out_valid), 0);
      chk("t1_ready", int'(in_ready), 1);
      tick();

      // All-zero vector.
      in_valid = 1'b1; in_vec = 8'h00;
      tick();
      in_valid = 1'b0;
      @(negedge clk);
      chk("t2_zero", int'(zero_err), 1);
      chk("t2_valid", int'(out_valid), 0);
      chk("t2_ready", int'(in_ready), 1);
      tick();
      @(negedge clk);
      chk("t2_zero_off", int'(zero_err), 0);
      tick();

      // Stall.
      in_valid = 1'b1; in_vec = 8'b1000_0001; out_ready = 1'b0;
      tick();
      in_valid = 1'b0; in_vec = 8'h3C;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("t3_hold_idx", int'(out_idx), e81[0]);
         chk("t3_hold_rdy", int'(in_ready), 0);
         tick();
      end
      out_ready = 1'b1;
      @(negedge clk);
      chk("t3_idx0", int'(out_idx), e81[0]);
      chk("t3_last0", int'(out_last), 0);
      tick();
      @(negedge clk);
      chk("t3_idx1", int'(out_idx), e81[1]);
      chk("t3_last1", int'(out_last), 1);
      tick();

      // Back-to-back load on the final handshake.
      in_valid = 1'b1; in_vec = 8'b0000_0100;
      tick();
      in_vec = 8'b0001_0000;
      @(negedge clk);
      chk("t4_idx2", int'(out_idx), 2);
      chk("t4_last", int'(out_last), 1);
      chk("t4_ready", int'(in_ready), 1);
      tick();
      in_valid = 1'b0;
      @(negedge clk);
      chk("t4_valid", int'(out_valid), 1);
      chk("t4_idx4", int'(out_idx), 4);
      tick();

      // Reset in the middle of a scan.
      in_valid = 1'b1; in_vec = 8'hFF;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      #1;
      chk("t5_valid", int'(out_valid), 0);
      chk("t5_ready", int'(in_ready), 1);
      chk("t5_idx", int'(out_idx), 0);
      tick();
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("t5_quiet", int'(out_valid), 0);
         tick();
      end

      // 32-bit instance ordering.
      v32 = 1'b1; vec32 = 32'h8000_0001; or32 = 1'b1;
      tick();
      v32 = 1'b0; vec32 = '0;
      @(negedge clk);
      chk("w32_idx0", int'(idx32), e32[0]);
      chk("w32_last0", int'(last32), 0);
      tick();
      @(negedge clk);
      chk("w32_idx1", int'(idx32), e32[1]);
      chk("w32_last1", int'(last32), 1);
      tick();
      @(negedge clk);
      chk("w32_done", int'(ov32), 0);

      // Random traffic against the model.
      for (int c = 0; c < 2000; c++) begin
         tick();
         in_valid  = ($urandom_range(0, 2) != 0);
         in_vec    = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         if (c == 1000) rst = 1'b1;
         if (c == 1002) rst = 1'b0;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      repeat (12) tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/priority_scan_serializer.md
Name: priority_scan_serializer

Overview:
- Parametrised, sequential successor to the flat 8-bit combinational priority encoder.
- Accepts an INP_BIT-wide request vector through a valid/ready handshake, then emits the index of every set bit, one per output handshake.
- Bits are emitted in priority order: bit 0 is highest priority, as in the existing encoder.
- Sits between interrupt/request collectors and downstream single-index consumers (dispatch, arbitration, logging).

Parameters:
- INP_BIT, 8, request vector width; any value ≥ 2.
- OUT_BIT, $clog2(INP_BIT), index width; derived, not overridden.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  request vector present.
- in_ready  output  1  block can accept a vector this cycle.
- in_vec  input  INP_BIT  request vector.
- out_valid  output  1  out_idx valid.
- out_ready  input  1  consumer accepts out_idx.
- out_idx  output  OUT_BIT  index of the current highest-priority pending bit.
- out_last  output  1  current index is the final pending bit of this vector.
- zero_err  output  1  one-cycle pulse: an all-zero vector was accepted.
- busy  output  1  state is SCAN.

Behaviour:
- Registers: state (IDLE/SCAN), pend[INP_BIT-1:0], zero_err.
- Reset (async, immediate): state=IDLE, pend=0, zero_err=0.
- Output values while rst is asserted: out_valid=0, out_last=0, busy=0, in_ready=1, out_idx=0.
- Accept handshake: in_valid && in_ready.
- IDLE:
  - in_ready=1, out_valid=0.
  - Accept with in_vec≠0: pend<=in_vec, go to SCAN.
  - Accept with in_vec==0: stay IDLE; zero_err=1 for exactly the next cycle.
- SCAN:
  - out_valid=1.
  - out_idx = lowest set index of pend, combinational from pend.
  - out_last = (pend has exactly one bit set).
- Output handshake (out_valid && out_ready): clear bit out_idx in pend.
  - If out_last=0: stay in SCAN.
  - If out_last=1 and no new vector accepted that cycle: go to IDLE.
- Back-to-back: in_ready = IDLE || (SCAN && out_last && out_ready).
  - An accept on the final output handshake loads the new vector directly and stays in SCAN, with no idle bubble.
  - A zero vector accepted that way goes to IDLE and pulses zero_err.
- Latency:
  - First out_valid is asserted one cycle after the accept.
  - A vector with N set bits needs N output handshakes.
  - Full throughput: one index per cycle while out_ready=1.
- Stall: while out_valid && !out_ready, out_idx, out_last and pend hold stable.
- in_vec is ignored whenever no accept occurs; the block never captures it outside the handshake.
- Reset mid-SCAN: pending bits are discarded and out_valid drops immediately.
- No X-propagation: out_idx=0 whenever pend==0.

Optional Feature:
- Macro: PSCAN_MSB_FIRST_EN.
- Defined: priority is reversed; out_idx is the highest set index of pend, and bits are emitted from MSB to LSB. All handshake and timing rules are unchanged.
- Undefined: LSB-first, bit 0 highest priority (default).

Decomposition:
- Package pscan_pkg:
  - state enum {IDLE, SCAN}.
  - Function onehot_clear(vec, idx).
- Sub-module priority_pick:
  - Parametrised combinational pick of lowest (or, under the macro, highest) set bit.
  - Outputs idx[OUT_BIT], found, and single (exactly one bit set).
  - Reusable as the generalised replacement for the fixed 8-bit casex encoder.

Test Plan:
- Reset then in_vec=8'b1010_0110 accepted, out_ready=1 → out_idx 1,2,5,7 on four consecutive cycles; out_last=1 only with idx 7; then IDLE, in_ready=1.
- in_vec=8'b0000_0000 accepted → no out_valid; zero_err high exactly one cycle; in_ready stays 1.
- in_vec=8'b1000_0001, out_ready held 0 for 3 cycles → out_idx=0 stable, in_ready=0; release → idx 0 then 7.
- Back-to-back: vec 8'b0000_0100, next vec 8'b0001_0000 held valid → idx 2 (last) accepts the second vector in the same cycle; idx 4 on the next cycle, no bubble.
- Assert rst mid-scan of 8'hFF after two indices → out_valid=0 immediately; after release, in_ready=1 and nothing further is emitted.
- INP_BIT=32 (OUT_BIT=5), vec 32'h8000_0001; repeat with PSCAN_MSB_FIRST_EN → default order 0, 31; macro build order 31, 0.
